int_exc_unit: RTL

- Parametrised successor to the single-IRQ interrupt/exception logic in the pipeline controller.
- Sits beside the decoder at the ID stage. Latches edge-triggered interrupt requests from NUM_IRQ sources into a pending register and prioritises them against illegal-instruction exceptions.
- Holds kernel mode, EPC, cause and mask state, and issues one-cycle trap/return redirects to the PC mux and IF/ID flush logic.

---
 rtl/int_exc_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/int_exc_unit.sv
// Interrupt/exception unit for the ID stage: edge-latched IRQ pending bits, mask,
// kernel mode, EPC and cause, with one-cycle trap/return redirects.
module int_exc_unit #(
    parameter int              NUM_IRQ = 4,
    parameter int              PC_W    = 32,
    parameter logic [PC_W-1:0] IRQ_VEC = 32'h80000004,
    parameter logic [PC_W-1:0] EXC_VEC = 32'h80000008,
    parameter int              CAUSE_W = $clog2(NUM_IRQ) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ill_inst,
    input  logic               eret,
    input  logic               id_valid,
    input  logic [PC_W-1:0]    id_pc,
    input  logic               stall,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               kernel,
    output logic               trap,
    output logic [PC_W-1:0]    trap_pc,
    output logic               ret,
    output logic [PC_W-1:0]    epc,
    output logic [CAUSE_W-1:0] cause,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int                 IDX_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [CAUSE_W-1:0] CAUSE_IRQ = CAUSE_W'(1) << (CAUSE_W - 1);

    // Bit 0 is the highest priority source, so scan downwards and keep the last hit.
    function automatic logic [IDX_W-1:0] lowestIdx(input logic [NUM_IRQ-1:0] vec);
        lowestIdx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) lowestIdx = IDX_W'(i);
        end
    endfunction

    logic [NUM_IRQ-1:0] prevIrq;
    logic [NUM_IRQ-1:0] setVec;
    logic [NUM_IRQ-1:0] clrVec;
    logic [NUM_IRQ-1:0] enabledVec;
    logic [IDX_W-1:0]   irqIdx;
    logic               act;
    logic               takeExc;
    logic               takeIrq;
    logic               doRet;

    always_comb begin
        act        = id_valid & ~stall & ~reset;
        setVec     = irq_in & ~prevIrq;
        enabledVec = pending & ~mask;
        irqIdx     = lowestIdx(enabledVec);
        // An eret outside kernel mode is treated as an illegal instruction.
        takeExc    = act & ~kernel & (ill_inst | eret);
        takeIrq    = act & ~kernel & ~takeExc & (|enabledVec);
        doRet      = act & kernel & eret;
        clrVec     = takeIrq ? (NUM_IRQ'(1) << irqIdx) : '0;
    end

    assign trap    = takeExc | takeIrq;
    assign ret     = doRet;
    assign trap_pc = takeIrq ? IRQ_VEC : EXC_VEC;

    always_ff @(posedge clk) begin
        if (reset) begin
            prevIrq <= '0;
            pending <= '0;
            mask    <= '0;
            kernel  <= 1'b0;
            epc     <= '0;
            cause   <= '0;
        end else begin
            prevIrq <= irq_in;
            // Set after clear so a fresh edge on the bit being serviced is not lost.
            pending <= (pending & ~clrVec) | setVec;
            if (takeExc) begin
                epc    <= id_pc + PC_W'(4);
                cause  <= '0;
                kernel <= 1'b1;
            end else if (takeIrq) begin
                epc    <= id_pc;
                cause  <= CAUSE_IRQ | CAUSE_W'(irqIdx);
                kernel <= 1'b1;
            end else if (doRet) begin
                kernel <= 1'b0;
            end
            if (kernel && mask_we) mask <= mask_wdata;
        end
    end

endmodule
